uart_program_loader: RTL

UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

---
 rtl/uart_program_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_program_loader.sv
`timescale 1ns / 1ps
// Serial program loader: receives a framed byte stream (0x55, N, N data bytes, checksum) over
// 8N1 UART and writes it into program RAM. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
module uart_program_loader #(
    parameter int unsigned CLOCK_FREQ     = 27000000,
    parameter int unsigned BAUD_RATE      = 9600,
    parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       RX,
    output logic [3:0] ram_address,
    output logic [7:0] ram_data,
    output logic       ram_write_enable,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_error
);
    localparam int unsigned DIV  = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CntW = $clog2(DIV);
    localparam logic [CntW-1:0] BitEnd  = CntW'(DIV - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(DIV / 2 - 1);

    typedef enum logic [2:0] {BitIdle, BitStart, BitData, BitStop, BitWait} bit_state_e;
    typedef enum logic [1:0] {StIdle, StCount, StData, StCheck} frame_state_e;

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    bit_state_e      bit_q, bit_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid, frame_err, tmo_hit, abort;

    frame_state_e    state_q, state_d;
    logic [3:0]      addr_q, addr_d, ram_address_q, ram_address_d;
    logic [4:0]      rem_q, rem_d;
    logic [7:0]      sum_q, sum_d, ram_data_q, ram_data_d;
    logic            we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_prev_q     <= 1'b1;
            bit_q         <= BitIdle;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            state_q       <= StIdle;
            addr_q        <= '0;
            rem_q         <= '0;
            sum_q         <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            we_q          <= 1'b0;
            hold_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rx_meta_q     <= RX;
            rx_sync_q     <= rx_meta_q;
            rx_prev_q     <= rx_sync_q;
            bit_q         <= bit_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            sum_q         <= sum_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            we_q          <= we_d;
            hold_q        <= hold_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Bit engine: byte_valid / frame_err fire in the stop-bit sample cycle.
    always_comb begin
        bit_d      = bit_q;
        cnt_d      = cnt_q + CntW'(1);
        idx_d      = idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (bit_q)
            BitIdle: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) bit_d = BitStart;
            end
            BitStart: begin
                if (cnt_q == HalfEnd) begin
                    cnt_d = '0;
                    idx_d = '0;
                    bit_d = rx_sync_q ? BitIdle : BitData;
                end
            end
            BitData: begin
                if (cnt_q == BitEnd) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) bit_d = BitStop;
                end
            end
            BitStop: begin
                if (cnt_q == BitEnd) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                        bit_d      = BitIdle;
                    end else begin
                        frame_err = 1'b1;
                        bit_d     = BitWait;
                    end
                end
            end
            BitWait: begin
                cnt_d = '0;
                if (rx_sync_q) bit_d = BitIdle;
            end
            default: bit_d = BitIdle;
        endcase
    end

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    assign tmo_hit = (state_q != StIdle) && (tmo_q == TIMEOUT_CYCLES - 1);
    assign tmo_d   = (state_q == StIdle || byte_valid) ? '0 : tmo_q + 32'd1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) tmo_q <= '0;
        else            tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        sum_d         = sum_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        we_d          = 1'b0;
        done_d        = 1'b0;
        hold_d        = hold_q;
        err_d         = err_q;
        abort         = 1'b0;
        if (byte_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (shift_q == 8'h55) begin
                        state_d       = StCount;
                        hold_d        = 1'b1;
                        err_d         = 1'b0;
                        addr_d        = '0;
                        ram_address_d = '0;
                        sum_d         = '0;
                    end
                end
                StCount: begin
                    if (shift_q != 8'd0 && shift_q <= 8'd16) begin
                        rem_d   = shift_q[4:0];
                        state_d = StData;
                    end else begin
                        abort = 1'b1;
                    end
                end
                StData: begin
                    ram_data_d    = shift_q;
                    ram_address_d = addr_q;
                    we_d          = 1'b1;
                    // Internal pointer may wrap after byte 16; the output address never does.
                    addr_d        = addr_q + 4'd1;
                    sum_d         = sum_q + shift_q;
                    rem_d         = rem_q - 5'd1;
                    if (rem_q == 5'd1) state_d = StCheck;
                end
                StCheck: begin
                    if (shift_q == sum_q) begin
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        abort = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if ((frame_err || tmo_hit) && state_q != StIdle) abort = 1'b1;
        if (abort) begin
            state_d = StIdle;
            hold_d  = 1'b0;
            err_d   = 1'b1;
        end
    end

    assign ram_address      = ram_address_q;
    assign ram_data         = ram_data_q;
    assign ram_write_enable = we_q;
    assign cpu_hold         = hold_q;
    assign load_done        = done_q;
    assign load_error       = err_q;
endmodule
